// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd
//   Sequential binary-to-BCD converter (shift-and-add-3, one input bit per
//   clock) with a start/busy/done handshake and a registered result.
//
//   Parameters
//     BIN_W   unsigned input width, 1..32
//     DIGITS  BCD digits produced; must cover 2**BIN_W-1 (checked at elaboration)
//
//   Ports
//     clk       system clock, rising edge
//     reset     asynchronous, active-high reset
//     start     conversion request, sampled only while idle
//     bin_in    binary operand, captured when start is accepted
//     busy      high from the cycle after acceptance through the done cycle
//     done      one-cycle pulse, bcd_out is fresh during it
//     bcd_out   packed BCD result, MS digit in the top nibble
//     digit_en  leading-zero blank mask (only with BIN2BCD_BLANK_EN defined)
//
//   Optional feature macro: BIN2BCD_BLANK_EN
module seq_bin2bcd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     digit_en
`endif
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int SW = 4 * DIGITS;

    // Decimal digits needed for the largest BIN_W-bit value.
    function automatic int min_digits(input int w);
        longint v;
        int     d;
        v = (longint'(1) << w) - 1;
        d = 1;
        while (v >= 10) begin
            v = v / 10;
            d = d + 1;
        end
        return d;
    endfunction

    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
        $error("seq_bin2bcd: BIN_W=%0d outside 1..32", BIN_W);
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("seq_bin2bcd: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [BIN_W-1:0] bin_sr;
    logic [SW-1:0]    scratch, scr_cor, scr_nx;
    logic [CW-1:0]    cnt;
    logic             last_shift;

    assign last_shift = (state == SHIFT) && (cnt == CW'(1));
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // Add-3 correction on every digit from its pre-correction value, then
    // shift the next binary bit into the bottom of the scratch register.
    always_comb begin
        scr_cor = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scr_cor[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scr_nx = {scr_cor[SW-2:0], bin_sr[BIN_W-1]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // The result register loads on the final shift edge so that bcd_out is
    // already valid during the DONE cycle in which done is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= bin_in;
                        scratch <= '0;
                        cnt     <= CW'(BIN_W);
                    end
                end
                SHIFT: begin
                    bin_sr  <= bin_sr << 1;
                    scratch <= scr_nx;
                    cnt     <= cnt - CW'(1);
                    if (last_shift) bcd_out <= scr_nx;
                end
                default: ;
            endcase
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] en_nx;

    // A digit is shown if it or any more significant digit is nonzero;
    // the units digit is always shown.
    always_comb begin
        logic any;
        any   = 1'b0;
        en_nx = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any      = any | (scr_nx[4*i +: 4] != 4'd0);
            en_nx[i] = any;
        end
        en_nx[0] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           digit_en <= DIGITS'(1);
        else if (last_shift) digit_en <= en_nx;
    end
`endif

endmodule

// File: doc/seq_bin2bcd.md
Name: seq_bin2bcd

Overview:
Parametrised, sequential binary-to-BCD converter using shift-and-add-3 (double dabble), processing one binary bit per clock. It generalises the team's fixed 8-bit combinational converter to any input width and digit count, and adds a start/busy/done handshake plus a registered result. It sits between datapath counters or measurement registers and the seven-segment HEX decoders.

Parameters:
BIN_W, 8, width of the unsigned binary input; legal range 1..32.
DIGITS, 3, number of BCD output digits; must satisfy DIGITS >= ceil(BIN_W*log10(2)); an elaboration-time check fails the build otherwise.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a conversion; sampled only while busy=0.
bin_in  input  BIN_W  unsigned binary value; captured in the cycle start is accepted.
busy  output  1  high from the cycle after acceptance through the cycle done is high.
done  output  1  one-cycle pulse; bcd_out is valid and updated in this cycle.
bcd_out  output  4*DIGITS  packed BCD result; most significant digit in the top nibble; holds until the next done.
digit_en  output  DIGITS  leading-zero blank mask; present only when the optional feature is compiled in.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, bcd_out=0; internal shift register and counter cleared. digit_en=1 in bit 0 only, when the feature is present. A conversion in progress is abandoned with no done pulse.
- States: IDLE, SHIFT, DONE. busy = (state != IDLE).
- IDLE:
  - start=1: load bin_in into the binary shift register, clear the BCD scratch register, set bit counter=BIN_W, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, per cycle:
  - First, every scratch digit >= 5 gets +3. All digits are corrected in parallel from pre-correction values.
  - Then shift the whole {scratch, binary} register left by 1.
  - Decrement the counter. The cycle that brings the counter to 0 moves to DONE.
  - Exactly BIN_W SHIFT cycles.
- DONE: copy scratch to bcd_out, assert done for exactly this cycle, go to IDLE.
- Latency: start accepted at edge N; done high during cycle N+BIN_W+1. The next start is accepted one cycle after done. Throughput is one conversion per BIN_W+2 cycles.
- start while busy=1, including the DONE cycle, is ignored and not queued. bin_in changes while busy have no effect.
- bcd_out changes only in the DONE cycle or on reset. It never shows intermediate values.
- Digit arithmetic is 4-bit. After correction a digit never exceeds 15, and the final digits are always 0..9.
- Top digits beyond the input's range read 0.
- Counter width is $clog2(BIN_W+1).
- Input 0 yields all-zero digits.

Optional Feature:
Macro BIN2BCD_BLANK_EN.
- Defined: digit_en port exists and is registered alongside bcd_out, updating in the DONE cycle.
  - Bit i=1 if digit i is nonzero or any higher digit is nonzero.
  - Bit 0 is always 1, so the value 0 shows a single "0".
- Undefined: the digit_en port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Defaults, reset, then start with bin_in=255 at cycle 0 -> busy=1 for cycles 1..9, done high at cycle 9, bcd_out=12'h255. With blanking: digit_en=3'b111.
2. Defaults, bin_in=0, then bin_in=128, then bin_in=7, back-to-back starts, each issued the cycle after done -> bcd_out=12'h000, 12'h128, 12'h007 in turn. With blanking: digit_en=001, 111, 001.
3. Start bin_in=99; at cycle 4 pulse start with bin_in=200 -> the second start is ignored; done at cycle 9 with 12'h099; no second done pulse.
4. Start bin_in=200; assert reset during cycle 5 -> outputs 0 immediately, asynchronously; no done pulse. After release, start bin_in=42 -> done 9 cycles later, bcd_out=12'h042.
5. BIN_W=16, DIGITS=5, bin_in=65535 -> done at cycle 17, bcd_out=20'h65535. Then bin_in=10000 -> 20'h10000.
6. Illegal parameters BIN_W=10, DIGITS=3 (1023 needs 4 digits) -> elaboration fails.
